// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, single in-flight read tracking and 2-entry decode queue; FETCH_HALT_DETECT_EN enables halt-opcode stop
module instruction_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int INSTRUCTIONMEM_ADDR_WIDTH = 13,
  parameter logic [INSTRUCTIONMEM_ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic clock,
  input  logic reset,
  output logic [INSTRUCTIONMEM_ADDR_WIDTH-1:0] readAddr,
  input  logic [DATA_WIDTH-1:0] readData,
  input  logic branchTaken,
  input  logic [INSTRUCTIONMEM_ADDR_WIDTH-1:0] branchTarget,
  output logic instrValid,
  input  logic instrReady,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [INSTRUCTIONMEM_ADDR_WIDTH-1:0] instrPc,
  output logic halted
);
  localparam int AW = INSTRUCTIONMEM_ADDR_WIDTH;
  logic [AW-1:0] fetch_pc, inflight_pc;
  logic inflight;
  logic [DATA_WIDTH-1:0] q_data [2];
  logic [AW-1:0] q_pc [2];
  logic [1:0] count, occ, base;
  logic pop, push, issue;
  assign instrValid = count != 2'd0;
  assign instruction = q_data[0];
  assign instrPc = q_pc[0];
  assign pop = instrValid & instrReady;
  assign push = inflight & ~branchTaken & ~halted;
  assign occ = count + 2'(inflight) - 2'(pop);
  assign base = count - 2'(pop);
  assign issue = branchTaken | ((occ < 2'd2) & ~halted);
  assign readAddr = reset ? RESET_PC : (branchTaken ? branchTarget : fetch_pc);
  // PC, in-flight tracking and queue; a push lands behind whatever survives this cycle's pop
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      count <= 2'd0;
      q_data[0] <= '0;
      q_data[1] <= '0;
      q_pc[0] <= '0;
      q_pc[1] <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= readAddr;
        fetch_pc <= readAddr + AW'(1);
      end
      if (branchTaken) count <= 2'd0;
      else begin
        if (pop) begin
          q_data[0] <= q_data[1];
          q_pc[0] <= q_pc[1];
        end
        if (push) begin
          q_data[base == 2'd0 ? 0 : 1] <= readData;
          q_pc[base == 2'd0 ? 0 : 1] <= inflight_pc;
        end
        count <= base + 2'(push);
      end
    end
  end
  // the issue rule must keep a full queue from ever receiving a push
  always_ff @(posedge clock) begin
    if (!reset) assert (!(push && !pop && count == 2'd2));
  end
`ifdef FETCH_HALT_DETECT_EN
  // halt once a halt word enters the queue; the read issued alongside it is squashed via push
  always_ff @(posedge clock) begin
    if (reset || branchTaken) halted <= 1'b0;
    else if (push && readData[DATA_WIDTH-1 -: 6] == HALT_OPCODE) halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed stimulus with scoreboard-checked delivery order
module tb_instruction_fetch_unit;
  logic clock = 0, reset, branchTaken, instrReady, instrValid, halted, halt_mode;
  logic [12:0] readAddr, branchTarget, instrPc;
  logic [31:0] readData, instruction;
  int total = 0, bad = 0;
  typedef struct {logic [12:0] pc; logic [31:0] d;} exp_t;
  exp_t sb[$];

  instruction_fetch_unit dut (
    .clock(clock), .reset(reset), .readAddr(readAddr), .readData(readData),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .instrValid(instrValid),
    .instrReady(instrReady), .instruction(instruction), .instrPc(instrPc), .halted(halted)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [12:0] a);
    return (halt_mode && a == 13'd3) ? 32'hFC000000 : {19'b0, a};
  endfunction

  // one-cycle registered instruction memory
  always @(posedge clock) readData <= word(readAddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_pc(input int pc);
    exp_t e;
    e.pc = 13'(pc);
    e.d = word(13'(pc));
    sb.push_back(e);
  endtask

  // monitor: every accepted head must be the next scoreboard entry
  always @(negedge clock) begin
    if (!reset && instrValid && instrReady) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected delivery: got pc %0d expected none", instrPc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("deliver pc", 32'(instrPc), 32'(e.pc));
        check("deliver word", instruction, e.d);
      end
    end
  end

  task automatic startup_check();
    @(negedge clock);
    check("c0 valid", 32'(instrValid), 0);
    check("c0 instruction", instruction, 0);
    check("c0 pc", 32'(instrPc), 0);
    check("c0 halted", 32'(halted), 0);
    check("c0 readAddr", 32'(readAddr), 0);
    @(negedge clock);
    check("c1 valid", 32'(instrValid), 0);
    @(negedge clock);
    check("c2 valid", 32'(instrValid), 1);
    check("c2 pc", 32'(instrPc), 0);
  endtask

  task automatic stall_at(input int pc);
    int n = 0;
    bit found = 0;
    instrReady = 1;
    while (!found) begin
      @(negedge clock);
      if (instrValid && 32'(instrPc) == pc - 1) found = 1;
      else if (++n > 60) begin
        total++;
        bad++;
        $display("FAIL stall timeout: got no head pc %0d expected within 60 cycles", pc - 1);
        found = 1;
      end
    end
    @(posedge clock); #1 instrReady = 0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check("stall head valid", 32'(instrValid), 1);
    check("stall head pc", 32'(instrPc), 32'(pc));
  endtask

  task automatic branch_to(input int t);
    @(posedge clock); #1;
    instrReady = 1;
    branchTaken = 1;
    branchTarget = 13'(t);
    @(posedge clock); #1 branchTaken = 0;
    @(negedge clock);
    check("branch t+1 valid", 32'(instrValid), 0);
    check("branch t+1 halted", 32'(halted), 0);
    @(negedge clock);
    check("branch t+2 valid", 32'(instrValid), 1);
    check("branch t+2 pc", 32'(instrPc), 32'(t));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    reset = 1; instrReady = 0; branchTaken = 1; branchTarget = 13'd55; halt_mode = 0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check("reset valid", 32'(instrValid), 0);
    check("reset instruction", instruction, 0);
    check("reset pc", 32'(instrPc), 0);
    check("reset halted", 32'(halted), 0);
    check("reset readAddr over branch", 32'(readAddr), 0);
    @(posedge clock); #1 branchTaken = 0;
    for (int p = 0; p <= 7; p++) push_pc(p);
    @(posedge clock); #1 reset = 0; instrReady = 1;
    startup_check();
    stall_at(4);
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      @(negedge clock);
      check("hold pc", 32'(instrPc), 4);
      check("issue stopped", 32'(readAddr), 6);
    end
    @(posedge clock); #1 instrReady = 1;
    stall_at(7);
    for (int p = 100; p <= 103; p++) push_pc(p);
    branch_to(100);
    stall_at(103);
    push_pc(8190); push_pc(8191); push_pc(0);
    branch_to(8190);
    stall_at(1);
    @(posedge clock); #1 reset = 1;
    for (int p = 0; p <= 4; p++) push_pc(p);
    @(posedge clock); #1 reset = 0; instrReady = 1;
    startup_check();
    stall_at(5);
`ifdef FETCH_HALT_DETECT_EN
    @(posedge clock); #1 reset = 1; halt_mode = 1;
    sb.delete();
    for (int p = 0; p <= 3; p++) push_pc(p);
    @(posedge clock); #1 reset = 0; instrReady = 1;
    repeat (10) @(posedge clock);
    #1;
    @(negedge clock);
    check("halted set", 32'(halted), 1);
    check("halted no pc 4", 32'(instrValid), 0);
    push_pc(10); push_pc(11);
    branch_to(10);
    stall_at(12);
`endif
    @(posedge clock); #1;
    check("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
